// File: rtl/cc_multishiftcomparator_pkg.sv
// Shared definitions for the multi-channel shift comparator: the compare
// mode encodings, the per-channel FSM state type and a popcount helper.
package cc_multishiftcomparator_pkg;

    localparam logic [1:0] MODE_EQ      = 2'b00;
    localparam logic [1:0] MODE_NE      = 2'b01;
    localparam logic [1:0] MODE_OVERLAP = 2'b10;
    localparam logic [1:0] MODE_OFF     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_HIT  = 2'b10
    } state_t;

    // Counts set bits in a 32-bit vector. Callers zero-extend narrower
    // vectors, so up to 32 channels can share this helper.
    function automatic logic [5:0] popcount(input logic [31:0] vec);
        logic [5:0] total;
        total = '0;
        for (int i = 0; i < 32; i++) begin
            total = total + {5'b0, vec[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/cc_shiftcomparator_channel.sv
// One comparator channel: evaluates the masked condition against the
// shared reference and requires HOLD consecutive matching strobes before
// reporting a hit. Also keeps a sticky hit flag until cleared.
module cc_shiftcomparator_channel
    import cc_multishiftcomparator_pkg::*;
#(
    parameter int DATAWIDTH = 23,
    parameter int HOLD      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] data,
    input  logic [DATAWIDTH-1:0] value,
    input  logic [DATAWIDTH-1:0] mask,
    input  logic [1:0]           mode,
    input  logic                 sample,
    input  logic                 clear,
    output logic                 t0_n,
    output logic                 sticky_n,
    output logic                 hit_next,
    output logic                 enter_hit
);

    localparam int RUNW = $clog2(HOLD + 1);
    localparam logic [RUNW-1:0] RUN_HOLD = RUNW'(HOLD);
    localparam logic [RUNW-1:0] RUN_ONE  = RUNW'(1);

    state_t            state_q, state_d;
    logic [RUNW-1:0]   run_q, run_d;
    logic              sticky_q, sticky_d;
    logic [DATAWIDTH-1:0] masked_diff;
    logic [DATAWIDTH-1:0] masked_overlap;
    logic              cond;

    // Compare condition for the currently selected mode; a zero mask is
    // allowed and simply falls out of the arithmetic.
    always_comb begin
        masked_diff    = (data ^ value) & mask;
        masked_overlap = data & value & mask;
        cond           = 1'b0;
        case (mode)
            MODE_EQ:      cond = (masked_diff == '0);
            MODE_NE:      cond = (masked_diff != '0);
            MODE_OVERLAP: cond = (masked_overlap != '0);
            default:      cond = 1'b0;
        endcase
    end

    // State, run counter and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            run_q    <= '0;
            sticky_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            sticky_q <= sticky_d;
        end
    end

    // Next-state logic: clear wins, otherwise only a strobe advances the FSM.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        sticky_d = sticky_q;
        if (clear) begin
            state_d  = ST_IDLE;
            run_d    = '0;
            sticky_d = 1'b1;
        end else if (sample) begin
            case (state_q)
                ST_IDLE: begin
                    if (cond) begin
                        run_d   = RUN_ONE;
                        state_d = (RUN_ONE == RUN_HOLD) ? ST_HIT : ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (cond) begin
                        run_d   = run_q + RUN_ONE;
                        state_d = ((run_q + RUN_ONE) == RUN_HOLD) ? ST_HIT : ST_PEND;
                    end else begin
                        run_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_HIT: begin
                    if (!cond) begin
                        run_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    run_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
            if (state_d == ST_HIT && state_q != ST_HIT) begin
                sticky_d = 1'b0;
            end
        end
    end

    // Outputs: registered hit/sticky plus next-state views for the top.
    always_comb begin
        t0_n      = (state_q != ST_HIT);
        sticky_n  = sticky_q;
        hit_next  = (state_d == ST_HIT);
        enter_hit = (state_d == ST_HIT) && (state_q != ST_HIT);
    end

endmodule

// File: rtl/cc_multi_shift_comparator.sv
// Multi-channel registered shift comparator. Instantiates one comparator
// channel per data word, registers an any-hit flag from the next-state hit
// vector and keeps a saturating count of hit entries.
module cc_multi_shift_comparator
    import cc_multishiftcomparator_pkg::*;
#(
    parameter int DATAWIDTH = 23,
    parameter int CHANNELS  = 4,
    parameter int HOLD      = 2,
    parameter int CNTWIDTH  = 8
) (
    input  logic                          CC_MULTISHIFTCOMPARATOR_CLOCK_50,
    input  logic                          CC_MULTISHIFTCOMPARATOR_RESET_InLow,
    input  logic [CHANNELS*DATAWIDTH-1:0] CC_MULTISHIFTCOMPARATOR_data_InBUS,
    input  logic [DATAWIDTH-1:0]          CC_MULTISHIFTCOMPARATOR_value_InBUS,
    input  logic [DATAWIDTH-1:0]          CC_MULTISHIFTCOMPARATOR_mask_InBUS,
    input  logic [1:0]                    CC_MULTISHIFTCOMPARATOR_mode_In,
    input  logic                          CC_MULTISHIFTCOMPARATOR_sample_InHigh,
    input  logic                          CC_MULTISHIFTCOMPARATOR_clear_InHigh,
    output logic [CHANNELS-1:0]           CC_MULTISHIFTCOMPARATOR_T0_OutLow,
    output logic                          CC_MULTISHIFTCOMPARATOR_any_OutLow,
    output logic [CHANNELS-1:0]           CC_MULTISHIFTCOMPARATOR_sticky_OutLow,
    output logic [CNTWIDTH-1:0]           CC_MULTISHIFTCOMPARATOR_count_OutBUS
);

    localparam int SUMW = CNTWIDTH + 7;
    localparam logic [CNTWIDTH-1:0] CNT_MAX = {CNTWIDTH{1'b1}};

    logic                clk;
    logic                rst_n;
    logic [CHANNELS-1:0] hit_next_vec;
    logic [CHANNELS-1:0] enter_vec;
    logic [31:0]         enter_ext;
    logic [5:0]          enter_pop;
    logic [SUMW-1:0]     count_sum;
    logic [CNTWIDTH-1:0] count_q, count_d;
    logic                any_q, any_d;

    assign clk   = CC_MULTISHIFTCOMPARATOR_CLOCK_50;
    assign rst_n = CC_MULTISHIFTCOMPARATOR_RESET_InLow;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
        cc_shiftcomparator_channel #(
            .DATAWIDTH (DATAWIDTH),
            .HOLD      (HOLD)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .data      (CC_MULTISHIFTCOMPARATOR_data_InBUS[ch*DATAWIDTH +: DATAWIDTH]),
            .value     (CC_MULTISHIFTCOMPARATOR_value_InBUS),
            .mask      (CC_MULTISHIFTCOMPARATOR_mask_InBUS),
            .mode      (CC_MULTISHIFTCOMPARATOR_mode_In),
            .sample    (CC_MULTISHIFTCOMPARATOR_sample_InHigh),
            .clear     (CC_MULTISHIFTCOMPARATOR_clear_InHigh),
            .t0_n      (CC_MULTISHIFTCOMPARATOR_T0_OutLow[ch]),
            .sticky_n  (CC_MULTISHIFTCOMPARATOR_sticky_OutLow[ch]),
            .hit_next  (hit_next_vec[ch]),
            .enter_hit (enter_vec[ch])
        );
    end

    // Saturating count of channels entering HIT; any-hit follows next-state
    // so it lines up with T0 on the same edge.
    always_comb begin
        enter_ext = 32'(enter_vec);
        enter_pop = popcount(enter_ext);
        count_sum = SUMW'(count_q) + SUMW'(enter_pop);
        any_d     = ~(|hit_next_vec);
        count_d   = count_q;
        if (CC_MULTISHIFTCOMPARATOR_clear_InHigh) begin
            count_d = '0;
        end else if (count_sum > SUMW'(CNT_MAX)) begin
            count_d = CNT_MAX;
        end else begin
            count_d = count_sum[CNTWIDTH-1:0];
        end
    end

    // Counter and any-hit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            any_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            any_q   <= any_d;
        end
    end

    assign CC_MULTISHIFTCOMPARATOR_any_OutLow   = any_q;
    assign CC_MULTISHIFTCOMPARATOR_count_OutBUS = count_q;

endmodule
